// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU: accepts one op, holds operands for EXEC_CYCLES, returns tagged result.
// Optional macro ALU_ARB_FIXED_PRI_EN: requester 0 always wins a tie (default build is round robin).
module alu_arbiter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_equal,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_NOR  = 4'd5;
  localparam logic [3:0] ALU_OP_SLT  = 4'd6;
  localparam logic [3:0] ALU_OP_SLTU = 4'd7;
  localparam logic [3:0] ALU_OP_SLL  = 4'd8;
  localparam logic [3:0] ALU_OP_SRL  = 4'd9;
  localparam logic [3:0] ALU_OP_SRA  = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               id_q;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [3:0]         op_q;
  logic               grant_c;
  logic               accept_c;
  logic               capture_c;

  logic [WIDTH-1:0]   sum_c, diff_c, alu_z_c;
  logic               alu_ov_c, alu_ok_c, alu_equal_c, alu_zero_c;

  // Grant selection among the valid requesters
`ifdef ALU_ARB_FIXED_PRI_EN
  always_comb begin
    grant_c = ~req_valid[0];
  end
`else
  logic last;

  always_comb begin
    grant_c = 1'b0;
    case (req_valid)
      2'b10:   grant_c = 1'b1;
      2'b11:   grant_c = ~last;
      default: grant_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept_c) begin
      last <= grant_c;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and the combinational handshake toward the requesters
  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready = grant_c ? 2'b10 : 2'b01;
          state_nx  = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          capture_c = 1'b1;
          state_nx  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    accept_c = |(req_valid & req_ready);
  end

  // Shared ALU, fed only from the latched operand registers
  always_comb begin
    sum_c    = x_q + y_q;
    diff_c   = x_q - y_q;
    alu_z_c  = '0;
    alu_ov_c = 1'b0;
    alu_ok_c = 1'b1;
    case (op_q)
      ALU_OP_ADD: begin
        alu_z_c  = sum_c;
        alu_ov_c = (x_q[MSB] == y_q[MSB]) && (sum_c[MSB] != x_q[MSB]);
      end
      ALU_OP_SUB: begin
        alu_z_c  = diff_c;
        alu_ov_c = (x_q[MSB] != y_q[MSB]) && (diff_c[MSB] != x_q[MSB]);
      end
      ALU_OP_AND:  alu_z_c = x_q & y_q;
      ALU_OP_OR:   alu_z_c = x_q | y_q;
      ALU_OP_XOR:  alu_z_c = x_q ^ y_q;
      ALU_OP_NOR:  alu_z_c = ~(x_q | y_q);
      ALU_OP_SLT:  alu_z_c = WIDTH'($signed(x_q) < $signed(y_q));
      ALU_OP_SLTU: alu_z_c = WIDTH'(x_q < y_q);
      ALU_OP_SLL:  alu_z_c = x_q << y_q[SH_W-1:0];
      ALU_OP_SRL:  alu_z_c = x_q >> y_q[SH_W-1:0];
      ALU_OP_SRA:  alu_z_c = $unsigned($signed(x_q) >>> y_q[SH_W-1:0]);
      default:     alu_ok_c = 1'b0;
    endcase
    alu_equal_c = alu_ok_c && (x_q == y_q);
    alu_zero_c  = alu_ok_c && (alu_z_c == '0);
  end

  // Operand latch, hold counter and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      op_q         <= '0;
      cnt          <= '0;
      id_q         <= 1'b0;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_z        <= '0;
      rsp_equal    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      rsp_valid <= (state_nx == RESP);
      busy      <= (state_nx != IDLE);
      if (accept_c) begin
        x_q  <= grant_c ? req1_x  : req0_x;
        y_q  <= grant_c ? req1_y  : req0_y;
        op_q <= grant_c ? req1_op : req0_op;
        cnt  <= CNT_W'(EXEC_CYCLES - 1);
        id_q <= grant_c;
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture_c) begin
        rsp_id       <= id_q;
        rsp_z        <= alu_z_c;
        rsp_equal    <= alu_equal_c;
        rsp_overflow <= alu_ov_c;
        rsp_zero     <= alu_zero_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter (EXEC_CYCLES=3) plus hand-written multi-cycle sequences.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned EXEC  = 3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_RSV = 4'hF;

  logic             clk, rst;
  logic [1:0]       req_valid, req_ready;
  logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [3:0]       req0_op, req1_op;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_equal, rsp_overflow, rsp_zero, busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(WIDTH), .EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
    .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_equal(rsp_equal), .rsp_overflow(rsp_overflow),
    .rsp_zero(rsp_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] x0, y0;
    logic [3:0]  op0;
    logic [31:0] x1, y1;
    logic [3:0]  op1;
    logic        exp_id;
    logic [31:0] exp_z;
    logic        exp_eq, exp_ov, exp_zero;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, scramble inputs during EXEC, check latency/result, hand off
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    req_valid = v.valid;
    req0_x = v.x0; req0_y = v.y0; req0_op = v.op0;
    req1_x = v.x1; req1_y = v.y1; req1_op = v.op1;
    rsp_ready = 1'b1;
    #1;
    chk($sformatf("%s_ready", tag), 32'(req_ready), v.exp_id ? 32'd2 : 32'd1);
    tick();
    req0_x = 32'hDEAD_BEEF; req0_op = OP_OR;
    req1_x = 32'h1234_5678; req1_op = OP_XOR;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      chk($sformatf("%s_exec_busy", tag), 32'(busy), 32'd1);
      chk($sformatf("%s_exec_ready", tag), 32'(req_ready), 32'd0);
      tick();
      n++;
    end
    chk($sformatf("%s_latency", tag), 32'(n), 32'(EXEC));
    chk($sformatf("%s_resp_ready", tag), 32'(req_ready), 32'd0);
    chk($sformatf("%s_id", tag), 32'(rsp_id), 32'(v.exp_id));
    chk($sformatf("%s_z", tag), rsp_z, v.exp_z);
    chk($sformatf("%s_eq", tag), 32'(rsp_equal), 32'(v.exp_eq));
    chk($sformatf("%s_ov", tag), 32'(rsp_overflow), 32'(v.exp_ov));
    chk($sformatf("%s_zero", tag), 32'(rsp_zero), 32'(v.exp_zero));
    tick();
    chk($sformatf("%s_post_valid", tag), 32'(rsp_valid), 32'd0);
    chk($sformatf("%s_post_busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_post_idle_ready", tag), 32'(|req_ready), 32'd1);
    req_valid = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    logic [31:0] z_hold;
    logic        exp_id;

    vecs[0] = '{2'b01, 32'd34, 32'd36, OP_ADD, 32'd0, 32'd0, OP_ADD, 1'b0, 32'd70, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 32'd0, 32'd0, OP_ADD, 32'h6FFFFFEE, 32'h6FF7FFFE, OP_ADD, 1'b1, 32'hDFF7FFEC, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 32'd5, 32'd5, OP_SUB, 32'd0, 32'd0, OP_ADD, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2'b10, 32'd0, 32'd0, OP_ADD, 32'd7, 32'd7, OP_RSV, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 32'hF0F000FF, 32'h0FF00F0F, OP_AND, 32'd0, 32'd0, OP_ADD, 1'b0, 32'h00F0000F, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 32'h80000000, 32'd1, OP_SUB, 32'd0, 32'd0, OP_ADD, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 32'd0, 32'd0, OP_ADD, 32'hFFFFFFFF, 32'd1, OP_SLT, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 32'h80000000, 32'd4, OP_SRA, 32'd0, 32'd0, OP_ADD, 1'b0, 32'hF8000000, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{2'b10, 32'd0, 32'd0, OP_ADD, 32'd1, 32'd31, OP_SLL, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req0_x = '0; req0_y = '0; req0_op = '0;
    req1_x = '0; req1_y = '0; req1_op = '0;
    tick();
    tick();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_z", rsp_z, 32'd0);
    chk("rst_flags", {29'd0, rsp_equal, rsp_overflow, rsp_zero}, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
    chk("idle_no_req_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Response back-pressure: held stable, no acceptance while stalled
    req_valid = 2'b01; req0_x = 32'd1; req0_y = 32'd2; req0_op = OP_ADD;
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b11;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("hold_latency", 32'(n), 32'(EXEC));
    z_hold = rsp_z;
    chk("hold_z_first", z_hold, 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold_z_%0d", i), rsp_z, 32'd3);
      chk($sformatf("hold_ready_%0d", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hold_release_ready", 32'(req_ready), 32'd0);
    tick();
    chk("hold_post_valid", 32'(rsp_valid), 32'd0);
    chk("hold_post_busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    tick();

    // Reset during the second EXEC cycle drops the in-flight op
    req_valid = 2'b01; req0_x = 32'd9; req0_y = 32'd9; req0_op = OP_ADD;
    tick();
    tick();
    req_valid = 2'b11;
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 2'b00;
    rst = 1'b0;
    for (int i = 0; i < EXEC + 2; i++) begin
      tick();
      chk($sformatf("mid_dropped_%0d", i), 32'(rsp_valid), 32'd0);
    end

    // Both requesters held valid across four transactions
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      exp_id = 1'b0;
`else
      exp_id = (i % 2) == 1;
`endif
      v = '{2'b11, 32'd100, 32'd1, OP_SUB, 32'd3, 32'd4, OP_ADD,
            exp_id, exp_id ? 32'd7 : 32'd99, 1'b0, 1'b0, 1'b0};
      run_vec(v, $sformatf("rr%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
